usb_fs_tx_arbiter: RTL

//   Shares the single USB FS transmit engine between NUM_REQ protocol engines
//   (index 0 = OUT PE handshakes, 1 = IN PE data, others free).

---
 rtl/usb_fs_pkg.sv | 20 ++
 rtl/usb_fs_prio_enc.sv | 29 ++
 rtl/usb_fs_tx_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/usb_fs_pkg.sv
// Shared USB FS definitions: PID codes and the tx arbiter state encoding.
// Imported by usb_fs_tx_arbiter and usb_fs_prio_enc.
package usb_fs_pkg;

  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/usb_fs_prio_enc.sv
// Fixed-priority encoder: lowest set bit of req wins (one-hot + binary index).
module usb_fs_prio_enc
  import usb_fs_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    // Walk downward so the lowest set index is the last writer.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IW'(i);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_fs_tx_arbiter.sv
// Shares one USB FS tx engine among NUM_REQ protocol engines, fixed priority.
// Optional grant watchdog enabled by defining USB_FS_TX_ARB_TIMEOUT_EN.
//
// state    | meaning
// ARB_IDLE | no grant; pick lowest pending/strobing requester
// ARB_BUSY | grant held; tx path muxed to requester until tx_pkt_end
module usb_fs_tx_arbiter
  import usb_fs_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_pkt_start,
  input  logic [4*NUM_REQ-1:0] req_pid,
  input  logic [NUM_REQ-1:0]   req_data_avail,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_data_get,
  output logic [NUM_REQ-1:0]   req_pkt_end,
  output logic                 tx_pkt_start,
  output logic [3:0]           tx_pid,
  output logic                 tx_data_avail,
  output logic [7:0]           tx_data,
  input  logic                 tx_data_get,
  input  logic                 tx_pkt_end,
  output logic                 timeout_flag
);

  localparam int GW = idx_width(NUM_REQ);

  arb_state_t         state;
  logic [GW-1:0]      grant;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] pending_nxt;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] win_oh;
  logic [GW-1:0]      win_idx;
  logic               win_any;
  logic [3:0]         win_pid;
  logic [3:0]         pid_q [NUM_REQ];
  logic               busy;
  logic               timeout_hit;

  assign busy = (state == ARB_BUSY);
  assign cand = pending | req_pkt_start;

  usb_fs_prio_enc #(
    .N  (NUM_REQ),
    .IW (GW)
  ) u_prio_enc (
    .req    (cand),
    .onehot (win_oh),
    .idx    (win_idx),
    .any    (win_any)
  );

  // A same-cycle strobe carries a fresher pid than the latched copy.
  always_comb begin
    win_pid = 4'b0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i])
        win_pid = req_pkt_start[i] ? req_pid[4*i +: 4] : pid_q[i];
    end
  end

  // The winner's request moves into service at grant time, so any strobe
  // seen during BUSY (even from the grantee) survives as a new request.
  always_comb begin
    pending_nxt = cand;
    if (!busy)
      pending_nxt = cand & ~win_oh;
  end

  always_comb begin
    tx_data_avail = 1'b0;
    tx_data       = 8'h00;
    req_data_get  = '0;
    req_pkt_end   = '0;
    if (busy) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant == GW'(i)) begin
          tx_data_avail   = req_data_avail[i];
          tx_data         = req_data[8*i +: 8];
          req_data_get[i] = tx_data_get;
          req_pkt_end[i]  = tx_pkt_end;
        end
      end
    end
  end

`ifdef USB_FS_TX_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;

  logic [TW-1:0] wd_cnt;

  // Reloaded while idle so it starts fresh on every BUSY entry.
  always_ff @(posedge clk) begin
    if (reset)
      wd_cnt <= '0;
    else if (!busy)
      wd_cnt <= TW'(TIMEOUT_CYCLES - 1);
    else if (wd_cnt != '0)
      wd_cnt <= wd_cnt - 1'b1;
  end

  assign timeout_hit = busy && (wd_cnt == '0) && !tx_pkt_end;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ARB_IDLE;
      grant        <= '0;
      pending      <= '0;
      tx_pkt_start <= 1'b0;
      tx_pid       <= 4'b0000;
      timeout_flag <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
        pid_q[i] <= 4'b0000;
    end else begin
      tx_pkt_start <= 1'b0;
      timeout_flag <= timeout_hit;
      pending      <= pending_nxt;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_pkt_start[i])
          pid_q[i] <= req_pid[4*i +: 4];
      end
      case (state)
        ARB_IDLE: begin
          if (win_any) begin
            tx_pkt_start <= 1'b1;
            tx_pid       <= win_pid;
            grant        <= win_idx;
            state        <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (tx_pkt_end || timeout_hit)
            state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
